bcd_timer_ctrl: RTL and testbench

BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

---
 rtl/bcd_timer_ctrl.sv | 77 +++++++
 tb/tb_bcd_timer_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: two-digit BCD down-timer with edge-triggered start/stop and a validated preset load
module bcd_timer_ctrl #(
  parameter int PRESCALE = 4
) (
  input  logic       CK,
  input  logic       nClear,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [7:0] preset,
  output logic [7:0] Q,
  output logic       running,
  output logic       done,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [7:0] LAST = 8'(PRESCALE - 1);
  state_t state, state_n;
  logic [7:0] presc, presc_n, q_n, q_dec;
  logic start_d, stop_d, start_re, stop_re, tick, valid, done_n, err_n;
  always_comb begin
    start_re = start & ~start_d;
    stop_re = stop & ~stop_d;
    valid = preset[7:4] <= 4'd9 && preset[3:0] <= 4'd9;
    tick = presc == LAST;
    q_dec = Q[3:0] == 4'd0 ? {Q[7:4] - 4'd1, 4'd9} : {Q[7:4], Q[3:0] - 4'd1};
    state_n = state;
    presc_n = presc;
    q_n = Q;
    done_n = 1'b0;
    err_n = 1'b0;
    if (state == RUN) begin
      if (stop_re)
        state_n = PAUSE;
      else if (tick) begin
        presc_n = 8'd0;
        q_n = q_dec;
        if (q_dec == 8'h00) begin
          state_n = DONE;
          done_n = 1'b1;
        end
      end else
        presc_n = presc + 8'd1;
    end else if (load) begin
      if (valid) begin
        q_n = preset;
        state_n = IDLE;
        presc_n = 8'd0;
      end else
        err_n = 1'b1;
    end else if (start_re && Q != 8'h00) begin
      state_n = RUN;
      presc_n = state == PAUSE ? presc : 8'd0;
    end
  end
  always_ff @(posedge CK) begin
    if (!nClear) begin
      state <= IDLE;
      presc <= 8'd0;
      Q <= 8'h00;
      start_d <= 1'b0;
      stop_d <= 1'b0;
      running <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      Q <= q_n;
      start_d <= start;
      stop_d <= stop;
      running <= state_n == RUN;
      done <= done_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: directed stimulus checked every cycle against a decimal-count timer model
module tb_bcd_timer_ctrl;
  localparam int PRESCALE = 4;
  logic CK = 1'b0, nClear = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0;
  logic [7:0] preset = 8'h00;
  logic [7:0] Q;
  logic running, done, err;
  int nvec = 0, nbad = 0;
  logic chk = 1'b0;
  bcd_timer_ctrl #(.PRESCALE(PRESCALE)) dut (
    .CK(CK), .nClear(nClear), .start(start), .stop(stop), .load(load),
    .preset(preset), .Q(Q), .running(running), .done(done), .err(err)
  );
  initial forever #5 CK = ~CK;
  typedef struct packed {
    logic [6:0] cnt;
    logic       run;
    logic       paused;
    logic [7:0] phase;
    logic       sp;
    logic       tp;
    logic       dn;
    logic       er;
  } m_t;
  m_t m = '0;
  function automatic m_t step(m_t c);
    m_t n = c;
    logic rs, rp;
    n.dn = 1'b0;
    n.er = 1'b0;
    n.sp = start;
    n.tp = stop;
    rs = start && !c.sp;
    rp = stop && !c.tp;
    if (!nClear) return '0;
    if (c.run) begin
      if (rp) begin
        n.run = 1'b0;
        n.paused = 1'b1;
      end else begin
        n.phase = 8'((c.phase + 1) % PRESCALE);
        if (n.phase == 0) begin
          n.cnt = 7'(c.cnt - 1);
          if (n.cnt == 0) begin
            n.run = 1'b0;
            n.dn = 1'b1;
          end
        end
      end
    end else if (load) begin
      if (preset[7:4] < 10 && preset[3:0] < 10) begin
        n.cnt = 7'(preset[7:4] * 10 + preset[3:0]);
        n.paused = 1'b0;
        n.phase = '0;
      end else
        n.er = 1'b1;
    end else if (rs && c.cnt != 0) begin
      n.run = 1'b1;
      if (!c.paused) n.phase = '0;
      n.paused = 1'b0;
    end
    return n;
  endfunction
  function automatic logic [7:0] bcd(int c);
    return {4'(c / 10), 4'(c % 10)};
  endfunction
  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    @(posedge CK);
    m = step(m);
  end
  initial forever begin
    @(negedge CK);
    if (chk) begin
      check("model Q", Q, bcd(int'(m.cnt)));
      check("model running", {7'd0, running}, {7'd0, m.run});
      check("model done", {7'd0, done}, {7'd0, m.dn});
      check("model err", {7'd0, err}, {7'd0, m.er});
    end
  end
  task automatic cyc(int n);
    repeat (n) @(negedge CK);
  endtask
  initial begin
    cyc(1);
    chk = 1'b1;
    cyc(1);
    check("reset Q", Q, 8'h00);
    check("reset running", {7'd0, running}, 8'd0);
    check("reset done", {7'd0, done}, 8'd0);
    check("reset err", {7'd0, err}, 8'd0);
    nClear = 1'b1;
    load = 1'b1; preset = 8'h12;
    cyc(1);
    check("load 12", Q, 8'h12);
    load = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("run entered", {7'd0, running}, 8'd1);
    cyc(4);
    check("first step", Q, 8'h11);
    cyc(40);
    check("at 01", Q, 8'h01);
    check("no early done", {7'd0, done}, 8'd0);
    cyc(4);
    check("reach 00", Q, 8'h00);
    check("done pulse", {7'd0, done}, 8'd1);
    check("running falls", {7'd0, running}, 8'd0);
    cyc(1);
    check("done one cycle", {7'd0, done}, 8'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    check("done start ignored", {7'd0, running}, 8'd0);
    load = 1'b1; preset = 8'h03;
    cyc(1);
    load = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(8);
    check("03 run at 01", Q, 8'h01);
    cyc(4);
    check("03 run done", {7'd0, done}, 8'd1);
    cyc(1);
    load = 1'b1; preset = 8'h10;
    cyc(1);
    load = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    check("borrow 10->09", Q, 8'h09);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0; load = 1'b1; preset = 8'h1A;
    cyc(1);
    load = 1'b0;
    check("bad load err", {7'd0, err}, 8'd1);
    check("bad load Q kept", Q, 8'h09);
    cyc(1);
    check("err one cycle", {7'd0, err}, 8'd0);
    load = 1'b1; preset = 8'h05;
    cyc(1);
    load = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(20);
    check("pause holds 05", Q, 8'h05);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    check("resume phase kept", Q, 8'h05);
    cyc(1);
    check("resume step", Q, 8'h04);
    cyc(3);
    start = 1'b1; stop = 1'b1;
    cyc(1);
    check("stop beats tick", Q, 8'h04);
    check("stop beats start", {7'd0, running}, 8'd0);
    start = 1'b0; stop = 1'b0;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0; load = 1'b1; preset = 8'h1A;
    cyc(1);
    check("run ignores bad load", {7'd0, err}, 8'd0);
    check("tick with load", Q, 8'h03);
    preset = 8'h50;
    cyc(1);
    load = 1'b0;
    check("run ignores load", Q, 8'h03);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0; load = 1'b1; preset = 8'h07;
    cyc(1);
    load = 1'b0; start = 1'b1;
    cyc(3);
    check("pre-reset Q", Q, 8'h07);
    nClear = 1'b0;
    cyc(1);
    check("mid-run reset Q", Q, 8'h00);
    check("mid-run reset done", {7'd0, done}, 8'd0);
    nClear = 1'b1;
    cyc(2);
    check("start after reset", {7'd0, running}, 8'd0);
    start = 1'b0;
    load = 1'b1; preset = 8'h99;
    cyc(1);
    load = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    check("99 step", Q, 8'h98);
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
